// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for the UART receive deframer
package uart_rx_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

    typedef logic [7:0] uart_byte_t;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO for the UART receiver
module uart_rx_fifo #(
    parameter int  Depth  = 4,
    parameter type data_t = logic [7:0]
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  data_t data_i,
    output logic  full_o,
    input  logic  pop_i,
    output data_t data_o,
    output logic  empty_o
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: Depth must be a power of two and at least 2");
    end

    data_t       r_mem [Depth];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Pointers carry one extra wrap bit so equal indices mean empty or full.
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = empty_o ? data_t'(0) : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
        end
    end

    // Storage write; contents are masked by empty_o so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 serial line deserializer with buffered byte output
module uart_rx_deframer
    import uart_rx_pkg::*;
#(
    parameter int ClkFreq   = 1_000_000_000,
    parameter int Baud      = 20_000_000,
    parameter int FifoDepth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       clr_i,
    output logic       busy_o
);
    localparam int BitCycles  = bit_cycles(ClkFreq, Baud);
    localparam int HalfCycles = BitCycles / 2;
    localparam int CntW       = $clog2(BitCycles);
    localparam logic [CntW-1:0] CntBit  = CntW'(BitCycles - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HalfCycles - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    if (BitCycles < 4) begin : g_bad_baud
        $error("uart_rx_deframer: ClkFreq/Baud must be at least 4");
    end

    logic           r_sync1;
    logic           r_rx_s;
    logic           r_rx_s_q;
    logic [1:0]     r_prime;
    uart_rx_state_e r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]     r_bit_idx;
    uart_byte_t     r_shift;
    logic           r_frame_err;
    logic           r_overflow;

    uart_rx_state_e  w_state_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [2:0]      w_bit_idx_nxt;
    uart_byte_t      w_shift_nxt;
    logic            w_push;
    logic            w_frame_err_nxt;
    logic            w_fall;
    logic            w_cnt_zero;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_pop;

    assign w_fall     = r_rx_s_q && !r_rx_s;
    assign w_cnt_zero = (r_cnt == '0);

    // Two-flop synchronizer plus one delayed copy for edge detection.
    // r_prime marks when the synchronizer holds real line samples rather than
    // its reset value, so a line held low across reset release is not mistaken
    // for an idle-high line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_q <= 1'b1;
            r_prime  <= 2'b00;
        end else begin
            r_sync1  <= rx_i;
            r_rx_s   <= r_sync1;
            r_rx_s_q <= r_rx_s;
            r_prime  <= {r_prime[0], 1'b1};
        end
    end

    // FSM state, bit counter, bit index, shift register and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= WAIT_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state logic: mid-bit sampling of start, data and stop bits.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_push          = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (r_rx_s && r_prime[1]) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = CntHalf;
                end
            end
            START: begin
                if (w_cnt_zero) begin
                    if (!r_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                        w_cnt_nxt     = CntBit;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt     = CntBit;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            STOP: begin
                if (w_cnt_zero) begin
                    if (r_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    assign w_pop = !w_fifo_empty && ready_i;

    // Sticky overflow: a byte completed while full with no pop; set beats clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .Depth  (FifoDepth),
        .data_t (uart_byte_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .full_o  (w_fifo_full),
        .pop_i   (w_pop),
        .data_o  (data_o),
        .empty_o (w_fifo_empty)
    );

    assign valid_o     = !w_fifo_empty;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;
    assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
    localparam int BIT   = 50;
    localparam int HALF  = 25;
    localparam int DEPTH = 4;
    localparam int STOP_SAMPLE = 2 + HALF + 9 * BIT;
    localparam int VALID_RISE  = STOP_SAMPLE + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    logic [7:0] got[$];

    uart_rx_deframer #(
        .ClkFreq   (1_000_000_000),
        .Baud      (20_000_000),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clr_i       (clr),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready) got.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(BIT);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            tick(BIT);
        end
        rx = stop_bit;
        tick(BIT);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1;
        tick(3);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", busy_o); end
        rst = 1'b0;
        tick(10);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %0b expected 0", busy_o); end
    endtask

    task automatic test_single;
        int t0, rise;
        logic [7:0] d;
        logic v2;
        bit seen;
        got.delete(); ferr_cnt = 0; ready = 1'b1;
        t0 = cyc; rise = -1; seen = 0; d = 8'h00; v2 = 1'bx;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 700 && !seen; i++) begin
                    @(negedge clk);
                    if (valid_o) begin
                        seen = 1; rise = cyc - t0; d = data_o;
                        @(negedge clk);
                        v2 = valid_o;
                    end
                end
            end
        join
        tick(20);
        checks++; if (rise !== VALID_RISE) begin errors++; $display("FAIL single_rise_cycle: got %0d expected %0d", rise, VALID_RISE); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", d); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL single_pop: valid got %0b expected 0", v2); end
        checks++; if (ferr_cnt !== 0 || overflow_o !== 1'b0) begin errors++; $display("FAIL single_flags: ferr %0d ovf %0b expected 0 0", ferr_cnt, overflow_o); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", got.size()); end
    endtask

    task automatic test_glitch;
        got.delete(); ferr_cnt = 0; ready = 1'b1;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_detect: busy got %0b expected 1", busy_o); end
        tick(600);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %0b expected 0", busy_o); end
        checks++; if (got.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL glitch_output: bytes %0d ferr %0d expected 0 0", got.size(), ferr_cnt); end
    endtask

    task automatic test_frame_error;
        got.delete(); ferr_cnt = 0; ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        tick(200);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ferr_wait_idle: busy got %0b expected 1", busy_o); end
        rx = 1'b1;
        tick(20);
        send_frame(8'h7E, 1'b1);
        tick(20);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h7E) begin errors++; $display("FAIL ferr_next_byte: got %0h expected 7e", got[0]); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_q[$];
        logic exp_ovf;
        got.delete(); ferr_cnt = 0; ready = 1'b0; exp_ovf = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(b));
            else exp_ovf = 1'b1;
        end
        tick(20);
        checks++; if (overflow_o !== exp_ovf) begin errors++; $display("FAIL ovf_set: got %0b expected %0b", overflow_o, exp_ovf); end
        checks++; if (data_o !== exp_q[0]) begin errors++; $display("FAIL ovf_head: got %0h expected %0h", data_o, exp_q[0]); end
        ready = 1'b1;
        tick(20);
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
        checks++; if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_drained: valid %0b ovf %0b expected 0 1", valid_o, overflow_o); end
        clr = 1'b1; tick(1); clr = 1'b0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow_o); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        got.delete(); ferr_cnt = 0; ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(STOP_SAMPLE);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(5);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_pop_ovf: got %0b expected 0", overflow_o); end
        ready = 1'b1;
        tick(20);
        checks++; if (got.size() !== exp_q.size()) begin errors++; $display("FAIL full_pop_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_pop_order[%0d]: got %0h expected %0h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        got.delete(); ferr_cnt = 0; ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(10);
        b = 8'h99;
        rx = 1'b0; tick(BIT);
        for (int k = 0; k < 4; k++) begin rx = b[k]; tick(BIT); end
        rx = b[4]; tick(20);
        rst = 1'b1; tick(1);
        checks++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL midrst_fifo: valid %0b data %0h expected 0 0", valid_o, data_o); end
        checks++; if (busy_o !== 1'b1 || frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: busy %0b ferr %0b ovf %0b expected 1 0 0", busy_o, frame_err_o, overflow_o); end
        rst = 1'b0; rx = 1'b1; ready = 1'b1;
        tick(600);
        checks++; if (got.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL midrst_no_output: bytes %0d ferr %0d expected 0 0", got.size(), ferr_cnt); end
        send_frame(8'h42, 1'b1);
        tick(20);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h42) begin errors++; $display("FAIL midrst_next_byte: got %0h expected 42", got[0]); end
        end
        got.delete(); ferr_cnt = 0;
        rx = 1'b0; rst = 1'b1; tick(3); rst = 1'b0;
        tick(700);
        checks++; if (busy_o !== 1'b1 || got.size() !== 0 || ferr_cnt !== 0) begin errors++; $display("FAIL low_at_reset: busy %0b bytes %0d ferr %0d expected 1 0 0", busy_o, got.size(), ferr_cnt); end
        rx = 1'b1;
        tick(10);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL low_then_idle: busy got %0b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sent[$];
        logic [7:0] b;
        got.delete(); ferr_cnt = 0; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            sent.push_back(b);
            send_frame(b, 1'b1);
            if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 20));
        end
        tick(20);
        checks++; if (got.size() !== sent.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got.size(), sent.size()); end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %0h expected %0h", i, got[i], sent[i]); end
        end
        checks++; if (ferr_cnt !== 0 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_flags: ferr %0d ovf %0b expected 0 0", ferr_cnt, overflow_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
